// File: rtl/pupil_scan_ctrl.sv
// Pupil-search sequencer: raster-scans the cell image, thresholds each ROM value, accumulates
// dark-pixel statistics and divides out the floor centroid. Define PUPIL_BBOX_EN for the bounding box.
module pupil_scan_ctrl #(
    parameter int COL_BITS = 4,
    parameter int ROW_BITS = 4,
    parameter int HALVING  = 3,
    parameter int THRESH   = 128
) (
    input  logic                         iCLK,
    input  logic                         iRST,
    input  logic                         iSTART,
    input  logic [10:0]                  iVAL,
    output logic [12:0]                  oX,
    output logic [12:0]                  oY,
    output logic                         oBUSY,
    output logic                         oDONE,
    output logic                         oFOUND,
    output logic [COL_BITS+ROW_BITS:0]   oCOUNT,
    output logic [COL_BITS-1:0]          oCX,
    output logic [ROW_BITS-1:0]          oCY,
    output logic [COL_BITS-1:0]          oXMIN,
    output logic [COL_BITS-1:0]          oXMAX,
    output logic [ROW_BITS-1:0]          oYMIN,
    output logic [ROW_BITS-1:0]          oYMAX
);

    localparam int C   = COL_BITS;
    localparam int R   = ROW_BITS;
    localparam int SXW = 2*C + R;
    localparam int SYW = C + 2*R;
    localparam int NW  = C + R + 1;

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DIV_X, S_DIV_Y, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [C-1:0]    r_col;
    logic [R-1:0]    r_row;
    logic [SXW-1:0]  r_sum_x;
    logic [SYW-1:0]  r_sum_y;
    logic [NW-1:0]   r_n;
    logic [NW-1:0]   r_rem;
    logic [C-1:0]    r_qx;
    logic [R-1:0]    r_qy;
    logic [7:0]      r_step;
    logic            r_found;
    logic [NW-1:0]   r_count;
    logic [C-1:0]    r_cx;
    logic [R-1:0]    r_cy;

    logic            w_dark, w_last_cell, w_div_last, w_div_bit, w_ge;
    logic [SXW-1:0]  w_sum_x_next;
    logic [SYW-1:0]  w_sum_y_next;
    logic [NW-1:0]   w_n_next, w_rem_next;
    logic [NW:0]     w_trial, w_diff;

    assign w_dark       = (iVAL < 11'(THRESH));
    assign w_last_cell  = (&r_col) && (&r_row);
    assign w_sum_x_next = r_sum_x + (w_dark ? SXW'(r_col) : SXW'(0));
    assign w_sum_y_next = r_sum_y + (w_dark ? SYW'(r_row) : SYW'(0));
    assign w_n_next     = r_n + NW'(w_dark);

    // Restoring divider: the partial remainder starts as dividend >> qbits, and the low
    // dividend bits are shifted out of the quotient register as quotient bits shift in.
    assign w_div_last = (r_state == S_DIV_X) ? (r_step == 8'(C-1)) : (r_step == 8'(R-1));
    assign w_div_bit  = (r_state == S_DIV_X) ? r_qx[C-1] : r_qy[R-1];
    assign w_trial    = {r_rem, w_div_bit};
    assign w_ge       = (w_trial >= {1'b0, r_n});
    assign w_diff     = w_trial - {1'b0, r_n};
    assign w_rem_next = NW'(w_ge ? w_diff : w_trial);

    assign oX     = (r_state == S_SCAN) ? 13'({r_col, {HALVING{1'b0}}}) : 13'd0;
    assign oY     = (r_state == S_SCAN) ? 13'({r_row, {HALVING{1'b0}}}) : 13'd0;
    assign oFOUND = r_found;
    assign oCOUNT = r_count;
    assign oCX    = r_cx;
    assign oCY    = r_cy;

    always_ff @(posedge iCLK) begin
        if (iRST) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        oBUSY  = 1'b0;
        oDONE  = 1'b0;
        case (r_state)
            S_IDLE:  if (iSTART) w_next = S_SCAN;
            S_SCAN: begin
                oBUSY = 1'b1;
                if (w_last_cell) w_next = (w_n_next != '0) ? S_DIV_X : S_DONE;
            end
            S_DIV_X: begin
                oBUSY = 1'b1;
                if (w_div_last) w_next = S_DIV_Y;
            end
            S_DIV_Y: begin
                oBUSY = 1'b1;
                if (w_div_last) w_next = S_DONE;
            end
            S_DONE: begin
                oDONE  = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_col   <= '0;
            r_row   <= '0;
            r_sum_x <= '0;
            r_sum_y <= '0;
            r_n     <= '0;
            r_rem   <= '0;
            r_qx    <= '0;
            r_qy    <= '0;
            r_step  <= '0;
            r_found <= 1'b0;
            r_count <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (iSTART) begin
                    r_col   <= '0;
                    r_row   <= '0;
                    r_sum_x <= '0;
                    r_sum_y <= '0;
                    r_n     <= '0;
                    r_found <= 1'b0;
                    r_count <= '0;
                    r_cx    <= '0;
                    r_cy    <= '0;
                end
                S_SCAN: begin
                    r_sum_x <= w_sum_x_next;
                    r_sum_y <= w_sum_y_next;
                    r_n     <= w_n_next;
                    r_col   <= r_col + 1'b1;
                    if (&r_col) r_row <= r_row + 1'b1;
                    if (w_last_cell) begin
                        r_rem  <= NW'(w_sum_x_next >> C);
                        r_qx   <= w_sum_x_next[C-1:0];
                        r_step <= '0;
                    end
                end
                S_DIV_X: begin
                    r_rem  <= w_rem_next;
                    r_qx   <= {r_qx[C-2:0], w_ge};
                    r_step <= r_step + 8'd1;
                    if (w_div_last) begin
                        r_rem  <= NW'(r_sum_y >> R);
                        r_qy   <= r_sum_y[R-1:0];
                        r_step <= '0;
                    end
                end
                S_DIV_Y: begin
                    r_rem  <= w_rem_next;
                    r_qy   <= {r_qy[R-2:0], w_ge};
                    r_step <= r_step + 8'd1;
                    if (w_div_last) begin
                        r_found <= 1'b1;
                        r_count <= r_n;
                        r_cx    <= r_qx;
                        r_cy    <= {r_qy[R-2:0], w_ge};
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PUPIL_BBOX_EN
    logic [C-1:0] r_xmin, r_xmax, r_o_xmin, r_o_xmax;
    logic [R-1:0] r_ymin, r_ymax, r_o_ymin, r_o_ymax;

    // Trackers start inverted so the first dark pixel sets both extremes.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_xmin <= '0; r_xmax <= '0; r_ymin <= '0; r_ymax <= '0;
            r_o_xmin <= '0; r_o_xmax <= '0; r_o_ymin <= '0; r_o_ymax <= '0;
        end else if (r_state == S_IDLE && iSTART) begin
            r_xmin <= '1; r_xmax <= '0; r_ymin <= '1; r_ymax <= '0;
            r_o_xmin <= '0; r_o_xmax <= '0; r_o_ymin <= '0; r_o_ymax <= '0;
        end else if (r_state == S_SCAN && w_dark) begin
            if (r_col < r_xmin) r_xmin <= r_col;
            if (r_col > r_xmax) r_xmax <= r_col;
            if (r_row < r_ymin) r_ymin <= r_row;
            if (r_row > r_ymax) r_ymax <= r_row;
        end else if (r_state == S_DIV_Y && w_div_last) begin
            r_o_xmin <= r_xmin; r_o_xmax <= r_xmax;
            r_o_ymin <= r_ymin; r_o_ymax <= r_ymax;
        end
    end

    assign oXMIN = r_o_xmin;
    assign oXMAX = r_o_xmax;
    assign oYMIN = r_o_ymin;
    assign oYMAX = r_o_ymax;
`else
    assign oXMIN = '0;
    assign oXMAX = '0;
    assign oYMIN = '0;
    assign oYMAX = '0;
`endif

endmodule

// File: tb/tb_pupil_scan_ctrl.sv
// Bench for pupil_scan_ctrl: stub image ROM, behavioural run model checked every cycle,
// directed scans with literal expectations, randomized images with start noise, mid-scan reset.
module tb_pupil_scan_ctrl;
    localparam int C = 4;
    localparam int R = 4;
`ifdef PUPIL_BBOX_EN
    localparam bit BBOX_ON = 1'b1;
`else
    localparam bit BBOX_ON = 1'b0;
`endif

    logic        iCLK = 1'b0;
    logic        iRST, iSTART;
    logic [10:0] iVAL;
    logic [12:0] oX, oY;
    logic        oBUSY, oDONE, oFOUND;
    logic [8:0]  oCOUNT;
    logic [3:0]  oCX, oCY, oXMIN, oXMAX, oYMIN, oYMAX;

    logic [10:0] img [16][16];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // model state: run in progress, cycles since accepted start, run length, published results
    bit m_active = 1'b0;
    int m_t = 0, m_len = 0;
    int e_n = 0, e_cx = 0, e_cy = 0, e_xmin = 0, e_xmax = 0, e_ymin = 0, e_ymax = 0;
    int p_n, p_cx, p_cy, p_xmin, p_xmax, p_ymin, p_ymax;

    pupil_scan_ctrl dut (
        .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iVAL(iVAL),
        .oX(oX), .oY(oY), .oBUSY(oBUSY), .oDONE(oDONE), .oFOUND(oFOUND),
        .oCOUNT(oCOUNT), .oCX(oCX), .oCY(oCY),
        .oXMIN(oXMIN), .oXMAX(oXMAX), .oYMIN(oYMIN), .oYMAX(oYMAX)
    );

    always #5 iCLK = ~iCLK;

    assign iVAL = img[oY[6:3]][oX[6:3]];

    task automatic compute_pending();
        int sx, sy;
        p_n = 0; sx = 0; sy = 0;
        p_xmin = 15; p_xmax = 0; p_ymin = 15; p_ymax = 0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                if (img[r][c] < 11'd128) begin
                    p_n++; sx += c; sy += r;
                    if (c < p_xmin) p_xmin = c;
                    if (c > p_xmax) p_xmax = c;
                    if (r < p_ymin) p_ymin = r;
                    if (r > p_ymax) p_ymax = r;
                end
        if (p_n == 0) begin
            p_cx = 0; p_cy = 0; p_xmin = 0; p_xmax = 0; p_ymin = 0; p_ymax = 0;
        end else begin
            p_cx = sx / p_n; p_cy = sy / p_n;
        end
    endtask

    task automatic clear_results();
        e_n = 0; e_cx = 0; e_cy = 0; e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0;
    endtask

    initial forever begin
        @(posedge iCLK);
        cyc++;
        if (iRST) begin
            m_active = 1'b0; m_t = 0; clear_results();
        end else if (m_active) begin
            if (m_t == m_len) m_active = 1'b0;
            else begin
                m_t++;
                if (m_t == m_len) begin
                    e_n = p_n; e_cx = p_cx; e_cy = p_cy;
                    e_xmin = p_xmin; e_xmax = p_xmax; e_ymin = p_ymin; e_ymax = p_ymax;
                end
            end
        end else if (iSTART) begin
            m_active = 1'b1; m_t = 0; clear_results(); compute_pending();
            m_len = 256 + ((p_n != 0) ? (C + R) : 0);
        end
    end

    initial forever begin
        logic [61:0] act, exp_v;
        logic [15:0] bb;
        logic [12:0] ex, ey;
        @(negedge iCLK);
        if (chk_en) begin
            ex = (m_active && m_t < 256) ? 13'((m_t % 16) * 8) : 13'd0;
            ey = (m_active && m_t < 256) ? 13'((m_t / 16) * 8) : 13'd0;
            bb = BBOX_ON ? {4'(e_xmin), 4'(e_xmax), 4'(e_ymin), 4'(e_ymax)} : 16'd0;
            exp_v = {m_active && (m_t < m_len), m_active && (m_t == m_len), e_n != 0,
                     9'(e_n), 4'(e_cx), 4'(e_cy), ex, ey, bb};
            act = {oBUSY, oDONE, oFOUND, oCOUNT, oCX, oCY, oX, oY, oXMIN, oXMAX, oYMIN, oYMAX};
            tests++;
            if (act !== exp_v) begin
                fails++;
                $display("FAIL cycle %0d outputs: got %h expected %h", cyc, act, exp_v);
            end
        end
    end

    task automatic check(string name, int got, int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic fill(logic [10:0] v);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) img[r][c] = v;
    endtask

    task automatic run_scan(string name, bit noisy, bit lit, int w_lat, int w_cnt, int w_cx,
                            int w_cy, int w_x0, int w_x1, int w_y0, int w_y1);
        int k, lat;
        @(negedge iCLK); iSTART = 1'b1;
        @(negedge iCLK); iSTART = 1'b0; k = cyc;
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            if (oDONE) begin lat = cyc - k; break; end
            if (noisy) iSTART = 1'($urandom_range(0, 1));
            @(negedge iCLK);
        end
        if (lat < 0) check({name, " done timeout"}, lat, 0);
        if (lit) begin
            check({name, " latency"}, lat, w_lat);
            check({name, " count"}, int'(oCOUNT), w_cnt);
            check({name, " found"}, int'(oFOUND), int'(w_cnt != 0));
            check({name, " cx"}, int'(oCX), w_cx);
            check({name, " cy"}, int'(oCY), w_cy);
            check({name, " bbox"}, int'({oXMIN, oXMAX, oYMIN, oYMAX}),
                  BBOX_ON ? int'({4'(w_x0), 4'(w_x1), 4'(w_y0), 4'(w_y1)}) : 0);
        end
        // start held high across the DONE edge must be ignored
        iSTART = noisy;
        @(negedge iCLK); iSTART = 1'b0;
        repeat (2) @(negedge iCLK);
    endtask

    initial begin
        int k, ndone;
        iRST = 1'b1; iSTART = 1'b0;
        fill(11'd255);
        repeat (3) @(negedge iCLK);
        chk_en = 1'b1;
        check("reset busy/done/found", int'({oBUSY, oDONE, oFOUND}), 0);
        check("reset count", int'(oCOUNT), 0);
        check("reset cx/cy", int'({oCX, oCY}), 0);
        check("reset x/y", int'({oX, oY}), 0);
        iRST = 1'b0;
        @(negedge iCLK);

        run_scan("all bright", 0, 1, 256, 0, 0, 0, 0, 0, 0, 0);
        img[9][5] = 11'd0;
        run_scan("single dark", 0, 1, 264, 1, 5, 9, 5, 5, 9, 9);
        fill(11'd255);
        img[2][6] = 11'd0; img[2][7] = 11'd0; img[3][6] = 11'd0; img[3][7] = 11'd0;
        run_scan("2x2 block", 0, 1, 264, 4, 6, 2, 6, 7, 2, 3);
        fill(11'd0);
        run_scan("all dark", 0, 1, 264, 256, 7, 7, 0, 15, 0, 15);
        fill(11'd255); img[0][3] = 11'd127;
        run_scan("thresh 127", 0, 1, 264, 1, 3, 0, 3, 3, 0, 0);
        img[0][3] = 11'd128;
        run_scan("thresh 128", 1, 1, 256, 0, 0, 0, 0, 0, 0, 0);

        for (int it = 0; it < 6; it++) begin
            int pct;
            case (it)
                0: pct = 2;  1: pct = 10; 2: pct = 40;
                3: pct = 90; 4: pct = 1;  default: pct = 60;
            endcase
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 16; c++)
                    img[r][c] = ($urandom_range(0, 99) < pct) ? 11'($urandom_range(0, 127))
                                                               : 11'($urandom_range(128, 2047));
            run_scan("random", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end

        fill(11'd0);
        @(negedge iCLK); iSTART = 1'b1;
        @(negedge iCLK); k = cyc;
        for (int i = 0; i < 99; i++) begin
            iSTART = 1'($urandom_range(0, 1));
            @(negedge iCLK);
        end
        check("pre-reset edge index", cyc - k, 99);
        iRST = 1'b1;
        @(negedge iCLK);
        iRST = 1'b0; iSTART = 1'b0;
        check("abort busy", int'(oBUSY), 0);
        check("abort count", int'(oCOUNT), 0);
        check("abort x/y", int'({oX, oY}), 0);
        ndone = 0;
        for (int i = 0; i < 300; i++) begin
            if (oDONE) ndone++;
            @(negedge iCLK);
        end
        check("abort no done", ndone, 0);
        fill(11'd255); img[9][5] = 11'd0;
        run_scan("after abort", 0, 1, 264, 1, 5, 9, 5, 5, 9, 9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
